// File: rtl/ddp_pkg.sv
// Shared constants, types and helpers for the board display pipeline:
// VGA 800x600@72 timing, 8x8 board cell layout and the commit FSM states.
package ddp_pkg;

  localparam int VGA_H_VIS = 800;
  localparam int VGA_H_FP = 56;
  localparam int VGA_H_SYNC = 120;
  localparam int VGA_H_BP = 64;
  localparam int VGA_V_VIS = 600;
  localparam int VGA_V_FP = 37;
  localparam int VGA_V_SYNC = 6;
  localparam int VGA_V_BP = 23;
  localparam int VGA_H_TOT = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_BLINK_FRAMES = 36;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  // Cell field bit positions within one 12-bit cell.
  localparam int CELL_W = 12;
  localparam int CUR_COLOR = 9;
  localparam int CUR_PRES = 8;
  localparam int PIECE_VLD = 4;
  localparam int SIDE = 3;
  localparam int TYPE_MSB = 2;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 8;
  localparam int N_CELLS = BOARD_ROWS * BOARD_COLS;
  localparam int BOARD_W = N_CELLS * CELL_W;

  typedef enum logic {
    IDLE,
    PENDING
  } sched_state_e;

  // All-ones except the cursor-present bit of every cell.
  function automatic logic [BOARD_W-1:0] cursor_mask();
    logic [BOARD_W-1:0] m;
    m = '1;
    for (int k = 0; k < N_CELLS; k++) m[k*CELL_W+CUR_PRES] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel/line counters with registered, mutually aligned
// enables and syncs, plus a strobe on the last cycle of the visible frame.
module vga_timing_gen
  import ddp_pkg::*;
#(
  parameter int H_VIS = VGA_H_VIS,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP
) (
  input  logic              pclk,
  input  logic              rst,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              hen,
  output logic              ven,
  output logic              hs,
  output logic              vs,
  output logic              frame_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  logic [HCNT_W-1:0] h_nxt;
  logic [VCNT_W-1:0] v_nxt;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    h_nxt = hcnt + 1'b1;
    v_nxt = vcnt;
    if (hcnt == HCNT_W'(H_TOT - 1)) begin
      h_nxt = '0;
      v_nxt = (vcnt == VCNT_W'(V_TOT - 1)) ? '0 : vcnt + 1'b1;
    end
  end

  // Decoding from the next count keeps every output aligned with hcnt/vcnt.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      hen  <= 1'b1;
      ven  <= 1'b1;
      hs   <= 1'b0;
      vs   <= 1'b0;
    end else begin
      hcnt <= h_nxt;
      vcnt <= v_nxt;
      hen  <= (h_nxt < HCNT_W'(H_VIS));
      ven  <= (v_nxt < VCNT_W'(V_VIS));
      hs   <= (h_nxt >= HCNT_W'(HS_BEG)) && (h_nxt <= HCNT_W'(HS_END));
      vs   <= (v_nxt >= VCNT_W'(VS_BEG)) && (v_nxt <= VCNT_W'(VS_END));
    end
  end

  assign frame_end = (hcnt == HCNT_W'(H_TOT - 1)) && (vcnt == VCNT_W'(V_VIS - 1));

endmodule

// File: rtl/frame_board_scheduler.sv
// Frame timing plus tear-free board snapshot commit at vertical-blank entry.
// Optional cursor blink on the output path is enabled by CURSOR_BLINK_EN.
module frame_board_scheduler
  import ddp_pkg::*;
#(
  parameter int H_VIS = VGA_H_VIS,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP
`ifdef CURSOR_BLINK_EN
  ,
  parameter int BLINK_FRAMES = VGA_BLINK_FRAMES
`endif
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [BOARD_W-1:0] upd_board,
  output logic               upd_ready,
  output logic [BOARD_W-1:0] board_data,
  output logic [HCNT_W-1:0]  hcnt,
  output logic [VCNT_W-1:0]  vcnt,
  output logic               hen,
  output logic               ven,
  output logic               hs,
  output logic               vs,
  output logic               frame_tick
);

  sched_state_e       state, state_nxt;
  logic [BOARD_W-1:0] pending;
  logic [BOARD_W-1:0] committed;
  logic               xfer;
  logic               frame_end;
  logic               commit_en;

  vga_timing_gen #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_timing (
    .pclk     (pclk),
    .rst      (rst),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .hen      (hen),
    .ven      (ven),
    .hs       (hs),
    .vs       (vs),
    .frame_end(frame_end)
  );

  // Never any backpressure; only reset withholds ready.
  assign upd_ready = upd_valid & ~rst;
  assign xfer      = upd_valid & upd_ready;

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A transfer landing on the commit cycle re-arms PENDING for the next frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = PENDING;
      PENDING: if (frame_end && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit_en = (state == PENDING) && frame_end;
  end

  // NOTE: the snapshot buffers are plain registers, not a memory array, so
  // they are reset like any other state and a pending update is discarded.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pending    <= '0;
      committed  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (xfer)      pending   <= upd_board;
      if (commit_en) committed <= pending;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Masking after the commit register leaves the stored snapshot intact.
  assign board_data = blink_on ? committed : (committed & cursor_mask());
`else
  assign board_data = committed;
`endif

endmodule

// File: tb/tb_frame_board_scheduler.sv
// Self-checking bench for frame_board_scheduler using shrunken timing and a
// frame-level reference model (counters from elapsed cycles, commit windows).
module tb_frame_board_scheduler;
  import ddp_pkg::*;

  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
  localparam int V_VIS = 8, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BLINK = 3;

  logic               pclk = 1'b0;
  logic               rst = 1'b1;
  logic               upd_valid = 1'b0;
  logic [BOARD_W-1:0] upd_board = '0;
  logic               upd_ready;
  logic [BOARD_W-1:0] board_data;
  logic [HCNT_W-1:0]  hcnt;
  logic [VCNT_W-1:0]  vcnt;
  logic               hen, ven, hs, vs, frame_tick;

  always #5 pclk = ~pclk;

  frame_board_scheduler #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
`ifdef CURSOR_BLINK_EN
    ,
    .BLINK_FRAMES(BLINK)
`endif
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_board (upd_board),
    .upd_ready (upd_ready),
    .board_data(board_data),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hen       (hen),
    .ven       (ven),
    .hs        (hs),
    .vs        (vs),
    .frame_tick(frame_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycles elapsed since reset, committed board, and the
  // latest snapshot offered since the previous commit point.
  int                 t = 0;
  int                 ticks = 0;
  logic               m_tick = 1'b0;
  logic [BOARD_W-1:0] m_board = '0;
  logic               win_valid = 1'b0;
  logic [BOARD_W-1:0] win_val = '0;

  task automatic check(input string name, input logic [BOARD_W-1:0] got,
                       input logic [BOARD_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int m_h();
    return t % H_TOT;
  endfunction

  function automatic int m_v();
    return (t / H_TOT) % V_TOT;
  endfunction

  function automatic logic [BOARD_W-1:0] m_board_out();
`ifdef CURSOR_BLINK_EN
    if ((ticks / BLINK) % 2 == 1) return m_board & cursor_mask();
`endif
    return m_board;
  endfunction

  task automatic model_edge();
    if (rst) begin
      t = 0;
      ticks = 0;
      m_tick = 1'b0;
      m_board = '0;
      win_valid = 1'b0;
    end else begin
      m_tick = (m_h() == H_TOT - 1) && (m_v() == V_VIS - 1);
      if (m_tick) begin
        ticks++;
        if (win_valid) m_board = win_val;
        win_valid = 1'b0;
      end
      if (upd_valid) begin
        win_valid = 1'b1;
        win_val = upd_board;
      end
      t++;
    end
  endtask

  task automatic compare_all();
    int h, v;
    h = m_h();
    v = m_v();
    check("hcnt", BOARD_W'(hcnt), BOARD_W'(h));
    check("vcnt", BOARD_W'(vcnt), BOARD_W'(v));
    check("hen", BOARD_W'(hen), BOARD_W'(h < H_VIS));
    check("ven", BOARD_W'(ven), BOARD_W'(v < V_VIS));
    check("hs", BOARD_W'(hs), BOARD_W'(h >= H_VIS + H_FP && h <= H_VIS + H_FP + H_SYNC - 1));
    check("vs", BOARD_W'(vs), BOARD_W'(v >= V_VIS + V_FP && v <= V_VIS + V_FP + V_SYNC - 1));
    check("frame_tick", BOARD_W'(frame_tick), BOARD_W'(m_tick));
    check("board_data", board_data, m_board_out());
  endtask

  task automatic tick();
    #1;
    check("upd_ready", BOARD_W'(upd_ready), BOARD_W'(upd_valid & ~rst));
    @(posedge pclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    upd_valid = 1'b0;
    while (!(m_h() == h && m_v() == v) && n < 2 * H_TOT * V_TOT) begin
      tick();
      n++;
    end
    if (n >= 2 * H_TOT * V_TOT) check("run_to_timeout", BOARD_W'(1), BOARD_W'(0));
  endtask

  task automatic offer(input logic [11:0] cell0);
    upd_board = '0;
    upd_board[11:0] = cell0;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    // Reset state, with ready held low while rst is asserted.
    rst = 1'b1;
    tick();
    tick();
    check("rst_hcnt", BOARD_W'(hcnt), '0);
    check("rst_vcnt", BOARD_W'(vcnt), '0);
    check("rst_hen", BOARD_W'(hen), BOARD_W'(1));
    check("rst_board", board_data, '0);
    upd_valid = 1'b1;
    #1 check("rst_ready_low", BOARD_W'(upd_ready), '0);
    upd_valid = 1'b0;
    rst = 1'b0;

    // Single transfer mid-frame commits only after the commit point.
    run_to(0, 2);
    offer(12'h015);
    run_to(H_TOT - 1, V_VIS - 1);
    check("pre_commit_board", board_data, '0);
    tick();
    check("commit_cell0", BOARD_W'(board_data[11:0]), BOARD_W'(12'h015));
    check("commit_tick", BOARD_W'(frame_tick), BOARD_W'(1));
    check("commit_vcnt", BOARD_W'(vcnt), BOARD_W'(V_VIS));
    check("commit_hcnt", BOARD_W'(hcnt), '0);

    // Latest transfer in a frame wins.
    run_to(0, 1);
    offer(12'h011);
    tick();
    tick();
    offer(12'h01E);
    run_to(H_TOT - 1, V_VIS - 1);
    check("pre_latest_cell0", BOARD_W'(board_data[11:0]), BOARD_W'(12'h015));
    tick();
    check("latest_cell0", BOARD_W'(board_data[11:0]), BOARD_W'(12'h01E));

    // Transfer exactly at the commit point defers to the next frame.
    run_to(0, 3);
    offer(12'h012);
    run_to(H_TOT - 1, V_VIS - 1);
    offer(12'h019);
    check("at_e_old_cell0", BOARD_W'(board_data[11:0]), BOARD_W'(12'h012));
    run_to(H_TOT - 1, V_VIS - 1);
    tick();
    check("at_e_next_cell0", BOARD_W'(board_data[11:0]), BOARD_W'(12'h019));

    // Reset pulse discards a pending snapshot.
    run_to(0, 2);
    offer(12'h01C);
    run_to(5, V_VIS / 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_board", board_data, '0);
    check("mid_rst_hcnt", BOARD_W'(hcnt), '0);
    check("mid_rst_vcnt", BOARD_W'(vcnt), '0);
    run_to(H_TOT - 1, V_VIS - 1);
    tick();
    check("no_commit_after_rst", board_data, '0);
    check("tick_after_rst", BOARD_W'(frame_tick), BOARD_W'(1));

    // Randomized traffic, including occasional resets, over several frames.
    for (int c = 0; c < 9 * H_TOT * V_TOT; c++) begin
      upd_valid = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < BOARD_W / 32; i++) upd_board[i*32+:32] = $urandom();
      rst = ($urandom_range(0, 2999) == 0);
      tick();
    end
    rst = 1'b0;
    upd_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_board_scheduler.md
Name: frame_board_scheduler

Overview:
- Owns VGA frame timing (800x600@72 Hz, 50 MHz pclk) for the board renderer; drives its hen/ven pixel enables.
- Arbitrates board-snapshot updates from game logic into the 64-cell x 12-bit board bus the renderer reads.
- Commits a new board snapshot only at vertical-blank entry, so a frame never shows a mix of two board states (no tearing).

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 56, horizontal front porch
- H_SYNC, 120, hsync width
- H_BP, 64, horizontal back porch
- V_VIS, 600, visible lines
- V_FP, 37, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 23, vertical back porch
- BLINK_FRAMES, 36, frames per cursor blink half-period (only with CURSOR_BLINK_EN)

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- upd_valid  in  1  game logic offers a new board snapshot
- upd_board  in  768  snapshot; cell k in bits [12k+11:12k]; bit9 cursor colour, bit8 cursor present, bit4 piece valid, bit3 side, bits2:0 type
- upd_ready  out  1  snapshot accepted this cycle
- board_data  out  768  committed snapshot to renderer
- hcnt  out  11  horizontal position 0..1039
- vcnt  out  10  vertical position 0..665
- hen  out  1  hcnt < H_VIS
- ven  out  1  vcnt < V_VIS
- hs  out  1  hsync, active-high
- vs  out  1  vsync, active-high
- frame_tick  out  1  one-cycle pulse at vblank entry, same cycle as commit

Behaviour:
- Reset values: hcnt=0, vcnt=0, hen=1, ven=1, hs=0, vs=0, board_data=0, pending buffer=0, upd_ready=0, frame_tick=0, FSM=IDLE.
- Counters: H_TOT=1040, V_TOT=666.
  - hcnt increments each cycle and wraps H_TOT-1 -> 0.
  - vcnt increments when hcnt wraps, and wraps V_TOT-1 -> 0.
  - All outputs are registered and decoded from the same counter value, so they are mutually aligned.
- hs=1 for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. [856,975].
- vs=1 for vcnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. [637,642].
- Commit point E: cycle where hcnt=H_TOT-1 and vcnt=V_VIS-1.
  - Commit-related outputs become visible on the edge after E, together with hcnt=0, vcnt=600.
- Handshake:
  - upd_ready is combinational = upd_valid in every non-reset cycle; there is never backpressure.
  - Transfer occurs when upd_valid && upd_ready.
  - The transfer writes upd_board into the pending buffer; the latest transfer wins.
- FSM:
  - IDLE: on transfer -> PENDING.
  - PENDING, at E: board_data <= pending; frame_tick=1; -> IDLE.
  - PENDING, transfer not at E: pending is overwritten; stay PENDING.
- Simultaneous transfer at E:
  - board_data takes the OLD pending value (or is unchanged if IDLE).
  - The new snapshot is loaded into pending; FSM = PENDING.
- frame_tick pulses at every E regardless of FSM state.
- board_data changes only at commit; otherwise it is stable, including across counter wrap.
- rst asserted mid-operation:
  - Everything returns to reset values next edge, and pending is discarded.
  - upd_ready=0 while rst=1.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A frame counter counts frame_ticks and toggles a blink phase every BLINK_FRAMES ticks; phase resets to ON.
  - While phase is OFF, board_data bit (12k+8) is forced 0 for all k; all other bits pass through.
  - The mask applies on the output path, so the committed snapshot is preserved.
- Undefined: no counter; board_data = committed snapshot exactly.

Decomposition:
- Shared package ddp_pkg holds:
  - Timing constants and derived H_TOT/V_TOT.
  - Cell field bit indices: CELL_W=12, CUR_COLOR=9, CUR_PRES=8, PIECE_VLD=4, SIDE=3, TYPE_MSB=2.
  - Board size constants: 8x8, 768-bit bus width.
  - FSM state enum {IDLE, PENDING}.
- Sub-module vga_timing_gen: counters, hen/ven/hs/vs, and an end-of-visible-frame strobe. The top module holds the commit FSM, pending buffer and blink mask.

Test Plan:
- Reset, run 2 frames -> hs period 1040 cycles with high width 120; vs high for 6 lines (vcnt 637..642); hen high 800 per line; frame_tick exactly once per 692640 cycles.
- Transfer board with cell0=12'h015 at vcnt=100 -> board_data stays 0 until the edge after E, then cell0=12'h015; frame_tick coincides with the change.
- Two transfers in one frame (cell0=12'h011, then 12'h01E) -> only 12'h01E committed; 12'h011 never appears on board_data.
- Transfer of 12'h019 exactly at E while 12'h012 pending -> commit 12'h012; 12'h019 committed at the following E.
- rst pulse with snapshot pending at vcnt=300 -> board_data=0, counters 0; no commit at the next E.
- CURSOR_BLINK_EN, cell5=12'h310 committed -> bit8 of cell5 reads 1 for 36 frames, then 0 for 36 frames; other bits constant at 12'h210 during OFF.
